// File: rtl/kyber_pkg.sv
// kyber_pkg
//   Shared Kyber arithmetic constants used by the NTT datapath blocks
//   (Barrett reduction, twiddle multiplier, butterfly post-processing).
//   No ports; import with `import kyber_pkg::*;`.
package kyber_pkg;

  // Kyber modulus and default coefficient width.
  localparam int unsigned KYBER_Q      = 3329;
  localparam int unsigned KYBER_DW     = 16;

  // Butterflies per NTT layer (n/2 for n = 256).
  localparam int unsigned KYBER_N_BFLY = 128;

  // Width of the per-layer output counter; must hold KYBER_N_BFLY-1.
  localparam int unsigned LAYER_CNT_W  = 7;

endpackage : kyber_pkg

// File: rtl/mod_csub.sv
// mod_csub
//   Single conditional subtraction: y = (x >= Q) ? x - Q : x.
//   Brings a value in 0..2Q-1 into 0..Q-1. Values outside that range are
//   still processed by the same rule and truncated to the output width.
// Ports:
//   x  input  [IW-1:0]  operand
//   y  output [OW-1:0]  conditionally reduced result
module mod_csub
  import kyber_pkg::*;
#(
  parameter int unsigned IW = KYBER_DW,
  parameter int unsigned OW = KYBER_DW,
  parameter int unsigned Q  = KYBER_Q
) (
  input  logic [IW-1:0] x,
  output logic [OW-1:0] y
);

  localparam logic [IW-1:0] Q_IW = IW'(Q);

  always_comb begin
    y = OW'((x >= Q_IW) ? x - Q_IW : x);
  end

endmodule : mod_csub

// File: rtl/ntt_butterfly_post.sv
// ntt_butterfly_post
//   Three-stage valid/ready pipeline that finishes a Cooley-Tukey butterfly:
//     S1: t1 = t mod Q (one conditional subtract), register u, t1, last
//     S2: sum = u + t1, diff = u - t1 (DW+1 bits)
//     S3: a = sum mod Q, b = diff mod Q (output registers)
//   Bubbles collapse; each stage moves when it is empty or its successor
//   moves. Latency 3 cycles, throughput 1 pair/cycle, capacity 3 pairs.
//   Also tracks layer length on the output side and flags range errors.
// Ports:
//   clk        input         clock, rising edge
//   rst        input         asynchronous active-low reset
//   in_valid   input         upstream pair valid
//   in_ready   output        pair accepted this cycle when in_valid is high
//   in_u       input  [DW]   butterfly top operand, legal 0..Q-1
//   in_t       input  [DW]   reduced twiddle product, legal 0..2Q-1
//   in_last    input         final butterfly of a layer
//   out_valid  output        result pair valid
//   out_ready  input         downstream accepts the pair
//   out_a      output [DW]   (u + t) mod Q
//   out_b      output [DW]   (u - t) mod Q
//   out_last   output        in_last travelling with its pair
//   err_range  output        sticky: out-of-range operand accepted
//   err_len    output        sticky: layer length other than N_BFLY seen
module ntt_butterfly_post
  import kyber_pkg::*;
#(
  parameter int unsigned Q      = KYBER_Q,
  parameter int unsigned DW     = KYBER_DW,
  parameter int unsigned N_BFLY = KYBER_N_BFLY  // 1..2**LAYER_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_u,
  input  logic [DW-1:0] in_t,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic          out_last,
  output logic          err_range,
  output logic          err_len
);

  localparam logic [DW-1:0]          Q_DW    = DW'(Q);
  localparam logic [DW:0]            Q_EXT   = (DW+1)'(Q);
  localparam logic [DW:0]            Q2_EXT  = (DW+1)'(2 * Q);
  localparam logic [LAYER_CNT_W-1:0] CNT_END = LAYER_CNT_W'(N_BFLY - 1);
  localparam logic [LAYER_CNT_W-1:0] CNT_ONE = LAYER_CNT_W'(1);

  // Stage S1
  logic          s1_valid;
  logic          s1_last;
  logic [DW-1:0] s1_u;
  logic [DW-1:0] s1_t1;

  // Stage S2; s2_diff holds the signed difference in two's complement,
  // bit DW is its sign.
  logic          s2_valid;
  logic          s2_last;
  logic [DW:0]   s2_sum;
  logic [DW:0]   s2_diff;

  // Stage advance and transfer strobes
  logic s1_adv;
  logic s2_adv;
  logic s3_adv;
  logic in_fire;
  logic out_fire;

  // Combinational next values
  logic [DW-1:0] t1_next;
  logic [DW-1:0] a_next;
  logic [DW-1:0] b_next;
  logic          range_bad;

  // Output-side layer counter
  logic [LAYER_CNT_W-1:0] cnt;

  // Handshake: the advance chain runs backwards from the output so a
  // stalled output still lets upstream bubbles be squeezed out.
  always_comb begin
    s3_adv   = !out_valid || out_ready;
    s2_adv   = !s2_valid  || s3_adv;
    s1_adv   = !s1_valid  || s2_adv;
    in_ready = s1_adv;
    in_fire  = in_valid  && in_ready;
    out_fire = out_valid && out_ready;
  end

  mod_csub #(
    .IW (DW),
    .OW (DW),
    .Q  (Q)
  ) u_csub_t (
    .x (in_t),
    .y (t1_next)
  );

  mod_csub #(
    .IW (DW + 1),
    .OW (DW),
    .Q  (Q)
  ) u_csub_a (
    .x (s2_sum),
    .y (a_next)
  );

  // Negative difference gets Q added back; arithmetic is modulo 2**(DW+1)
  // so the unsigned add on the two's-complement value is exact.
  always_comb begin
    b_next    = DW'(s2_diff[DW] ? s2_diff + Q_EXT : s2_diff);
    range_bad = (in_u >= Q_DW) || ({1'b0, in_t} >= Q2_EXT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_u      <= '0;
      s1_t1     <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_sum    <= '0;
      s2_diff   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_u    <= in_u;
          s1_t1   <= t1_next;
          s1_last <= in_last;
        end
      end

      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sum  <= {1'b0, s1_u} + {1'b0, s1_t1};
          s2_diff <= {1'b0, s1_u} - {1'b0, s1_t1};
          s2_last <= s1_last;
        end
      end

      if (s3_adv) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_a    <= a_next;
          out_b    <= b_next;
          out_last <= s2_last;
        end
      end
    end
  end

  // Sticky error flags and layer-length tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      err_range <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      if (in_fire && range_bad) begin
        err_range <= 1'b1;
      end

      if (out_fire) begin
        if (out_last) begin
          if (cnt != CNT_END) begin
            err_len <= 1'b1;
          end
          cnt <= '0;
        end else if (cnt == CNT_END) begin
          // Layer overran without a last marker: flag and restart count.
          err_len <= 1'b1;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule : ntt_butterfly_post

// File: tb/tb_ntt_butterfly_post.sv
// tb_ntt_butterfly_post
//   Self-checking bench for ntt_butterfly_post. Inputs are driven just after
//   the falling edge, outputs sampled 1 ns later; a queue holds expected
//   results computed with plain modular arithmetic.
module tb_ntt_butterfly_post;

  localparam int Q  = 3329;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_u;
  logic [DW-1:0] in_t;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          out_last;
  logic          err_range;
  logic          err_len;

  ntt_butterfly_post #(
    .Q      (3329),
    .DW     (16),
    .N_BFLY (128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_u      (in_u),
    .in_t      (in_t),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last),
    .err_range (err_range),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    bit last;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  bit   lat_chk  = 1'b0;
  bit   thru_chk = 1'b0;
  bit   rand_rdy = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: true modular butterfly for legal operands; for illegal
  // operands, the documented pass-through rules (one reduction of t, one
  // correction of each result), truncated to DW bits.
  function automatic void model(input int u, input int t, output int a, output int b);
    int t1, s, d;
    if (u < Q && t < 2 * Q) begin
      a = (u + t) % Q;
      b = (((u - t) % Q) + Q) % Q;
    end else begin
      t1 = (t >= Q) ? t - Q : t;
      s  = u + t1;
      d  = u - t1;
      a  = ((s >= Q) ? s - Q : s) & 16'hFFFF;
      b  = ((d < 0) ? d + Q : d) & 16'hFFFF;
    end
  endfunction

  // One cycle: inputs are already set; observe both handshakes, then move
  // to the next falling edge.
  task automatic tick(output bit fired);
    exp_t e;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    fired = in_valid && in_ready;
    if (thru_chk) check_eq("in_ready_stream", int'(in_ready), 1);
    if (fired) begin
      model(int'(in_u), int'(in_t), e.a, e.b);
      e.last = in_last;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("out_unexpected", int'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_a", int'(out_a), e.a);
        check_eq("out_b", int'(out_b), e.b);
        check_eq("out_last", int'(out_last), int'(e.last));
        if (lat_chk) check_eq("latency", cyc - e.cyc, 3);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int u, input int t, input bit last);
    bit f;
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_u     = DW'(u);
    in_t     = DW'(t);
    in_last  = last;
    do begin
      tick(f);
      n++;
    end while (!f && n < 64);
    if (!f) check_eq("send_timeout", n, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bit f;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  task automatic drain();
    bit f;
    int n;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick(f);
      n++;
    end
    if (exp_q.size() > 0) check_eq("drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic send_layer(input int len);
    for (int i = 0; i < len; i++) begin
      send($urandom_range(0, Q - 1), $urandom_range(0, 2 * Q - 1), i == len - 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit f;
    int idx;
    int pu[4];
    int pt[4];

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_u      = '0;
    in_t      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #3;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_a", int'(out_a), 0);
    check_eq("rst_out_b", int'(out_b), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    check_eq("rst_err_range", int'(err_range), 0);
    check_eq("rst_err_len", int'(err_len), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // Directed values with exact latency
    lat_chk = 1'b1;
    send(100, 3000, 1'b0);
    idle(4);
    send(3328, 6657, 1'b0);
    idle(4);
    check_eq("err_range_edge", int'(err_range), 0);
    send(0, 3329, 1'b0);
    idle(4);
    check_eq("err_range_q", int'(err_range), 0);
    send(5, 6658, 1'b0);
    idle(4);
    check_eq("err_range_set", int'(err_range), 1);

    // Backpressure: only three pairs fit while the output is stalled
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pu[i] = $urandom_range(0, Q - 1);
      pt[i] = $urandom_range(0, 2 * Q - 1);
    end
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      in_u     = DW'(pu[idx & 3]);
      in_t     = DW'(pt[idx & 3]);
      tick(f);
      if (f) idx++;
    end
    in_valid = (idx < 4);
    #1;
    check_eq("bp_in_ready", int'(in_ready), 0);
    check_eq("bp_accepts", idx, 3);
    out_ready = 1'b1;
    while (idx < 4) begin
      send(pu[idx], pt[idx], 1'b0);
      idx++;
    end
    drain();

    // Randomized traffic with random stalls on both sides
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send($urandom_range(0, Q - 1), $urandom_range(0, 2 * Q - 1), 1'b0);
    end
    drain();
    check_eq("err_range_sticky", int'(err_range), 1);

    // Layer length tracking from a clean start
    do_reset();
    check_eq("rst2_err_range", int'(err_range), 0);
    check_eq("rst2_err_len", int'(err_len), 0);
    lat_chk  = 1'b1;
    thru_chk = 1'b1;
    send_layer(128);
    thru_chk = 1'b0;
    drain();
    check_eq("len_128_ok", int'(err_len), 0);
    send_layer(100);
    drain();
    check_eq("len_100_err", int'(err_len), 1);

    // Reset with pairs in flight and a partially counted layer
    lat_chk = 1'b0;
    send(1, 2, 1'b0);
    send(3, 4, 1'b0);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom_range(0, Q - 1), $urandom_range(0, 2 * Q - 1), 1'b0);
    rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_err_len", int'(err_len), 0);
    check_eq("midrst_out_a", int'(out_a), 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq("stale_out", int'(out_valid), 0);
      tick(f);
    end
    lat_chk = 1'b1;
    send_layer(128);
    drain();
    check_eq("len_after_rst", int'(err_len), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ntt_butterfly_post
